// File: rtl/adaptive_pkg.sv
// Shared types and helpers for the adaptive-filter blocks: FSM state encoding,
// default word format and a generic signed saturator.
package adaptive_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_FRAC  = 15;

   // Clamp a wide signed value into a w-bit two's-complement range.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

// File: rtl/lms_tap_update.sv
// Single-tap LMS step: w' = sat(w + (e*x >>> (FRAC+MU_SHIFT))), with an optional
// leakage term when LMS_LEAKAGE_EN is defined.
module lms_tap_update
   import adaptive_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int FRAC     = DEF_FRAC,
   parameter int MU_SHIFT = 4
`ifdef LMS_LEAKAGE_EN
   , parameter int LEAK_SHIFT = 8
`endif
) (
   input  logic signed [WIDTH-1:0] w_i,
   input  logic signed [WIDTH-1:0] e_i,
   input  logic signed [WIDTH-1:0] x_i,
   output logic signed [WIDTH-1:0] w_o,
   output logic                    sat_o
);

   logic signed [2*WIDTH-1:0] prod;
   logic signed [63:0]        term;
   logic signed [63:0]        sum;
   logic signed [63:0]        clamped;

   always_comb begin
      prod = e_i * x_i;
      // Arithmetic shift floors toward -inf, folding mu into the fixed-point rescale.
      term = 64'(prod) >>> (FRAC + MU_SHIFT);
`ifdef LMS_LEAKAGE_EN
      sum  = 64'(w_i) - (64'(w_i) >>> LEAK_SHIFT) + term;
`else
      sum  = 64'(w_i) + term;
`endif
      clamped = saturate(sum, WIDTH);
      w_o     = clamped[WIDTH-1:0];
      sat_o   = (clamped != sum);
   end

endmodule

// File: rtl/lms_coeff_update.sv
// LMS coefficient updater: latches the error per accepted sample, then walks the
// taps one per cycle through a shared lms_tap_update. Option: LMS_LEAKAGE_EN.
module lms_coeff_update
   import adaptive_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int FRAC     = DEF_FRAC,
   parameter int TAPS     = 2,
   parameter int MU_SHIFT = 4
`ifdef LMS_LEAKAGE_EN
   , parameter int LEAK_SHIFT = 8
`endif
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_valid,
   input  logic signed [WIDTH-1:0] i_din,
   input  logic signed [WIDTH-1:0] i_desired,
   input  logic signed [WIDTH-1:0] i_fir_out,
   input  logic                    i_ovr,
   input  logic                    i_clr_ovr,
   output logic [TAPS*WIDTH-1:0]   o_coeffs,
   output logic signed [WIDTH-1:0] o_error,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_ovr
);

   localparam int IDX_W = $clog2(TAPS);

   state_t                  state_q;
   logic [IDX_W-1:0]        idx_q;
   logic signed [WIDTH-1:0] w_q [TAPS];
   logic signed [WIDTH-1:0] x_q [TAPS];
   logic signed [WIDTH-1:0] err_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    ovr_q;

   logic signed [63:0]      diff;
   logic signed [63:0]      diff_sat;
   logic signed [WIDTH-1:0] err_d;
   logic                    err_sat;
   logic signed [WIDTH-1:0] w_sel;
   logic signed [WIDTH-1:0] x_sel;
   logic signed [WIDTH-1:0] w_new;
   logic                    tap_sat;

   always_comb begin
      diff     = 64'(i_desired) - 64'(i_fir_out);
      diff_sat = saturate(diff, WIDTH);
      err_d    = diff_sat[WIDTH-1:0];
      err_sat  = (diff_sat != diff);
      w_sel    = w_q[idx_q];
      x_sel    = x_q[idx_q];
   end

   lms_tap_update #(
      .WIDTH    (WIDTH),
      .FRAC     (FRAC),
      .MU_SHIFT (MU_SHIFT)
`ifdef LMS_LEAKAGE_EN
      , .LEAK_SHIFT (LEAK_SHIFT)
`endif
   ) u_tap (
      .w_i   (w_sel),
      .e_i   (err_q),
      .x_i   (x_sel),
      .w_o   (w_new),
      .sat_o (tap_sat)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         err_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         for (int k = 0; k < TAPS; k++) begin
            w_q[k] <= '0;
            x_q[k] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         // Later set assignments in this block override the clear.
         if (i_clr_ovr) ovr_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  err_q  <= err_d;
                  x_q[0] <= i_din;
                  for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_UPDATE;
                  if (err_sat || i_ovr) ovr_q <= 1'b1;
               end
            end
            ST_UPDATE: begin
               w_q[idx_q] <= w_new;
               if (tap_sat) ovr_q <= 1'b1;
               if (idx_q == IDX_W'(TAPS - 1)) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      o_coeffs = '0;
      for (int k = 0; k < TAPS; k++) o_coeffs[k*WIDTH +: WIDTH] = w_q[k];
   end

   assign o_error = err_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;
   assign o_ovr   = ovr_q;

endmodule

// File: tb/tb_lms_coeff_update.sv
// Directed + randomized bench for lms_coeff_update against an arithmetic LMS model.
module tb_lms_coeff_update;

   localparam int W  = 16;
   localparam int F  = 15;
   localparam int T  = 4;
   localparam int MU = 2;

   logic           clk = 1'b0;
   logic           rst, valid, ovr_in, clr;
   logic [W-1:0]   din, des, fir;
   logic [T*W-1:0] coeffs;
   logic [W-1:0]   err;
   logic           busy, done, ovr;

   int errors = 0;
   int checks = 0;

   longint mw [T];
   longint mx [T];
   longint me;
   bit     movr;

   always #5 clk = ~clk;

   lms_coeff_update #(.WIDTH(W), .FRAC(F), .TAPS(T), .MU_SHIFT(MU)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_valid   (valid),
      .i_din     (din),
      .i_desired (des),
      .i_fir_out (fir),
      .i_ovr     (ovr_in),
      .i_clr_ovr (clr),
      .o_coeffs  (coeffs),
      .o_error   (err),
      .o_busy    (busy),
      .o_done    (done),
      .o_ovr     (ovr)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint msat(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic logic [15:0] dut_w(input int k);
      return coeffs[k*W +: W];
   endfunction

   // Reference LMS step for one accepted sample set.
   task automatic model_accept(input logic [15:0] d_in, d_des, d_fir, input bit iovr, input bit iclr);
      longint diff, t, nv, s;
      bit set;
      set  = iovr;
      diff = longint'($signed(d_des)) - longint'($signed(d_fir));
      me   = msat(diff);
      if (me != diff) set = 1;
      for (int k = T - 1; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = longint'($signed(d_in));
      for (int k = 0; k < T; k++) begin
         t  = (me * mx[k]) >>> (F + MU);
`ifdef LMS_LEAKAGE_EN
         nv = mw[k] - (mw[k] >>> 8) + t;
`else
         nv = mw[k] + t;
`endif
         s  = msat(nv);
         if (s != nv) set = 1;
         mw[k] = s;
      end
      if (iclr) movr = 0;
      if (set) movr = 1;
   endtask

   task automatic model_reset();
      for (int k = 0; k < T; k++) begin
         mw[k] = 0;
         mx[k] = 0;
      end
      me   = 0;
      movr = 0;
   endtask

   task automatic compare_model(input string tag);
      for (int k = 0; k < T; k++) begin
         logic [15:0] e16;
         e16 = mw[k][15:0];
         check($sformatf("%s_w%0d", tag, k), dut_w(k), e16);
      end
      begin
         logic [15:0] ee;
         ee = me[15:0];
         check({tag, "_error"}, err, ee);
      end
      check({tag, "_ovr"}, ovr, movr);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   task automatic sample(input string tag, input logic [15:0] d_in, d_des, d_fir,
                         input bit iovr, input bit iclr, input bit pulse);
      int cnt;
      bit seen;
      @(negedge clk);
      din = d_in; des = d_des; fir = d_fir; ovr_in = iovr; clr = iclr; valid = 1;
      model_accept(d_in, d_des, d_fir, iovr, iclr);
      @(negedge clk);
      valid = 0; ovr_in = 0; clr = 0;
      cnt = 1; seen = 0;
      check({tag, "_busy"}, busy, 1'b1);
      while (!seen && cnt < 12) begin
         if (done) seen = 1;
         else begin
            if (pulse) begin
               valid  = 1'($urandom_range(0, 1));
               ovr_in = 1'($urandom_range(0, 1));
               din    = 16'($urandom);
               des    = 16'($urandom);
               fir    = 16'($urandom);
            end
            @(negedge clk);
            cnt++;
         end
      end
      valid = 0; ovr_in = 0;
      check({tag, "_done_latency"}, seen ? cnt : -1, 5);
      compare_model(tag);
   endtask

   initial begin
      rst = 1; valid = 0; ovr_in = 0; clr = 0; din = 0; des = 0; fir = 0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 0;

      check("rst_coeffs", coeffs, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ovr", ovr, 1'b0);
      check("rst_error", err, '0);

      // Single update from reset.
      sample("single", 16'h4000, 16'h4000, 16'h0000, 0, 0, 0);
      check("single_err_const", err, 16'h4000);
      check("single_w0_const", dut_w(0), 16'h0800);
      check("single_w123_const", coeffs[4*W-1:W], 48'h0);
      @(negedge clk);
      check("idle_busy", busy, 1'b0);

      // Reset while the tap walk is in progress.
      @(negedge clk);
      din = 16'h4000; des = 16'h4000; fir = 16'h0000; ovr_in = 1; valid = 1;
      @(negedge clk);
      valid = 0; ovr_in = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      model_reset();
      check("midrst_coeffs", coeffs, '0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_ovr", ovr, 1'b0);
      check("midrst_done", done, 1'b0);

      // Error saturation and sticky overflow.
      sample("errsat", 16'h1000, 16'h7FFF, 16'h8000, 0, 0, 0);
      check("errsat_err_const", err, 16'h7FFF);
      check("errsat_ovr_const", ovr, 1'b1);
      repeat (3) @(negedge clk);
      check("errsat_ovr_sticky", ovr, 1'b1);
      clr = 1;
      @(negedge clk);
      clr = 0;
      movr = 0;
      check("clr_ovr", ovr, 1'b0);
      // Set and clear in the same accept cycle: set wins.
      sample("setwins", 16'h0100, 16'h0000, 16'h0000, 1, 1, 0);
      check("setwins_ovr_const", ovr, 1'b1);
      @(negedge clk);
      clr = 1;
      @(negedge clk);
      clr = 0;
      movr = 0;

      // Coefficient saturation: w[0] must clamp positive.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         sample($sformatf("csat%0d", i), 16'h7FFF, 16'h7FFF, 16'h0000, 0, 0, 0);
         check($sformatf("csat%0d_w0_sign", i), dut_w(0) >> 15, 0);
      end
      check("csat_w0_clamp", dut_w(0), 16'h7FFF);
      check("csat_ovr", ovr, 1'b1);

      // Valid pulses while busy are ignored.
      do_reset();
      sample("busydrop_a", 16'h2345, 16'h3000, 16'h1000, 0, 0, 1);
      sample("busydrop_b", 16'h6000, 16'h1234, 16'hF000, 0, 0, 1);
      sample("busydrop_c", 16'h9ABC, 16'h0800, 16'h0000, 0, 0, 0);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 24; i++) begin
         sample($sformatf("rand%0d", i), 16'($urandom), 16'($urandom), 16'($urandom),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
